// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: the reserved tag, default widths and the
// functional-unit requester indices used on the common data bus.
package tomasulo_pkg;

    localparam int N_REQ_DEFAULT  = 4;
    localparam int TAG_W_DEFAULT  = 5;
    localparam int DATA_W_DEFAULT = 32;
    localparam int ICC_W          = 4;

    // A reservation-station tag of all ones never names a real producer.
    localparam logic [4:0] INVALID_TAG = 5'b11111;

    localparam int REQ_ADD   = 0;
    localparam int REQ_MUL   = 1;
    localparam int REQ_LOAD  = 2;
    localparam int REQ_LOGIC = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping from the top index to 0, as a one-hot grant plus its index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    int unsigned pos_s;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos_s = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_s = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos_s]) begin
                found        = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = PTR_W'(pos_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among functional units, with a
// one-edge mask on the previous winner and a registered broadcast stage.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEFAULT,
    parameter int TAG_W  = TAG_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        in_req,
    input  logic [N_REQ*TAG_W-1:0]  in_tag,
    input  logic [N_REQ*DATA_W-1:0] in_val,
    input  logic [N_REQ*ICC_W-1:0]  in_icc,
    input  logic                    in_cdb_hold,
    output logic [N_REQ-1:0]        out_grant,
    output logic                    out_CDB_broadcast,
    output logic [TAG_W-1:0]        out_CDB_tag,
    output logic [DATA_W-1:0]       out_CDB_val,
    output logic [ICC_W-1:0]        out_ICC_flags,
    output logic [1:0]              out_CDB_src,
    output logic                    out_err_invalid_tag
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TAG_W-1:0] BAD_TAG = TAG_W'(INVALID_TAG);

    logic [PTR_W-1:0]  ptr_r;
    logic [N_REQ-1:0]  mask_r;
    logic [N_REQ-1:0]  grant_r;
    logic              bcast_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] val_r;
    logic [ICC_W-1:0]  icc_r;
    logic [1:0]        src_r;
    logic              err_r;

    logic [N_REQ-1:0]  eligible_s;
    logic [N_REQ-1:0]  pick_grant_s;
    logic [PTR_W-1:0]  pick_idx_s;
    logic              pick_found_s;
    logic              do_grant_s;
    logic [N_REQ-1:0]  win_grant_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic [TAG_W-1:0]  sel_tag_s;
    logic [DATA_W-1:0] sel_val_s;
    logic [ICC_W-1:0]  sel_icc_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (eligible_s),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Eligibility, stall gating, pointer advance and winner data selection.
    always_comb begin
        eligible_s  = in_req & ~mask_r;
        do_grant_s  = pick_found_s & ~in_cdb_hold;
        win_grant_s = do_grant_s ? pick_grant_s : '0;
        if (pick_idx_s == PTR_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = pick_idx_s + PTR_W'(1);
        end
        sel_tag_s = in_tag[pick_idx_s*TAG_W +: TAG_W];
        sel_val_s = in_val[pick_idx_s*DATA_W +: DATA_W];
        sel_icc_s = in_icc[pick_idx_s*ICC_W +: ICC_W];
    end

    // Arbitration state and the registered CDB stage. The mask always
    // reloads from this edge's grant, so it lapses after one edge even
    // while the bus is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= '0;
            mask_r  <= '0;
            grant_r <= '0;
            bcast_r <= 1'b0;
            tag_r   <= BAD_TAG;
            val_r   <= '0;
            icc_r   <= '0;
            src_r   <= 2'd0;
            err_r   <= 1'b0;
        end else begin
            mask_r  <= win_grant_s;
            grant_r <= win_grant_s;
            if (do_grant_s) begin
                ptr_r   <= next_ptr_s;
                tag_r   <= sel_tag_s;
                val_r   <= sel_val_s;
                icc_r   <= sel_icc_s;
                src_r   <= 2'(pick_idx_s);
                bcast_r <= (sel_tag_s != BAD_TAG);
                err_r   <= err_r | (sel_tag_s == BAD_TAG);
            end else begin
                bcast_r <= 1'b0;
            end
        end
    end

    assign out_grant           = grant_r;
    assign out_CDB_broadcast   = bcast_r;
    assign out_CDB_tag         = tag_r;
    assign out_CDB_val         = val_r;
    assign out_ICC_flags       = icc_r;
    assign out_CDB_src         = src_r;
    assign out_err_invalid_tag = err_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: one table row per clock edge, then a
// hand-written fairness run with all four units requesting.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_req;
    logic [19:0] in_tag;
    logic [127:0] in_val;
    logic [15:0] in_icc;
    logic        in_cdb_hold;
    logic [3:0]  out_grant;
    logic        out_CDB_broadcast;
    logic [4:0]  out_CDB_tag;
    logic [31:0] out_CDB_val;
    logic [3:0]  out_ICC_flags;
    logic [1:0]  out_CDB_src;
    logic        out_err_invalid_tag;

    cdb_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_req              (in_req),
        .in_tag              (in_tag),
        .in_val              (in_val),
        .in_icc              (in_icc),
        .in_cdb_hold         (in_cdb_hold),
        .out_grant           (out_grant),
        .out_CDB_broadcast   (out_CDB_broadcast),
        .out_CDB_tag         (out_CDB_tag),
        .out_CDB_val         (out_CDB_val),
        .out_ICC_flags       (out_ICC_flags),
        .out_CDB_src         (out_CDB_src),
        .out_err_invalid_tag (out_err_invalid_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hold;
        logic [3:0] req;
        logic       bad2;
        logic [3:0] exp_grant;
        logic       exp_bc;
        logic [1:0] exp_src;
        logic       exp_err;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    logic [4:0]  tag_c [4];
    logic [31:0] val_c [4];
    logic [3:0]  icc_c [4];

    int n_vec = 0;
    int n_bad = 0;

    logic [4:0]  m_tag;
    logic [31:0] m_val;
    logic [3:0]  m_icc;
    int          cnt [4];

    task automatic drive(input logic r, input logic h, input logic [3:0] q, input logic b2);
        rst         = r;
        in_cdb_hold = h;
        in_req      = q;
        for (int i = 0; i < 4; i++) begin
            in_tag[i*5 +: 5]   = tag_c[i];
            in_val[i*32 +: 32] = val_c[i];
            in_icc[i*4 +: 4]   = icc_c[i];
        end
        if (b2) in_tag[10 +: 5] = 5'b11111;
    endtask

    initial begin
        tag_c[0] = 5'd4;  val_c[0] = 32'h0000_0100; icc_c[0] = 4'h1;
        tag_c[1] = 5'd6;  val_c[1] = 32'h0000_0010; icc_c[1] = 4'h2;
        tag_c[2] = 5'd8;  val_c[2] = 32'h0000_0300; icc_c[2] = 4'h4;
        tag_c[3] = 5'd9;  val_c[3] = 32'h0000_0400; icc_c[3] = 4'h8;

        //           rst   hold  req      bad2  grant    bc    src   err
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1};
        vecs[25] = '{1'b0, 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        vecs[27] = '{1'b1, 1'b0, 4'b0110, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};

        m_tag = 5'b11111;
        m_val = 32'h0;
        m_icc = 4'h0;
        drive(1'b1, 1'b0, 4'b0000, 1'b0);

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].rst, vecs[v].hold, vecs[v].req, vecs[v].bad2);
            // Expected CDB payload: reset value, the winner's slice, or held.
            if (vecs[v].rst) begin
                m_tag = 5'b11111; m_val = 32'h0; m_icc = 4'h0;
            end else if (vecs[v].exp_grant != 4'b0000) begin
                m_tag = (vecs[v].bad2 && vecs[v].exp_src == 2'd2) ? 5'b11111 : tag_c[vecs[v].exp_src];
                m_val = val_c[vecs[v].exp_src];
                m_icc = icc_c[vecs[v].exp_src];
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({out_grant, out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_CDB_src, out_err_invalid_tag} !==
                {vecs[v].exp_grant, vecs[v].exp_bc, m_tag, m_val, m_icc, vecs[v].exp_src, vecs[v].exp_err}) begin
                n_bad++;
                $display("FAIL vec%0d: got grant=%b bc=%b tag=%0d val=%h icc=%h src=%0d err=%b, want grant=%b bc=%b tag=%0d val=%h icc=%h src=%0d err=%b",
                         v, out_grant, out_CDB_broadcast, out_CDB_tag, out_CDB_val, out_ICC_flags, out_CDB_src, out_err_invalid_tag,
                         vecs[v].exp_grant, vecs[v].exp_bc, m_tag, m_val, m_icc, vecs[v].exp_src, vecs[v].exp_err);
            end
        end

        // Fairness: all four requesting from reset for two full rounds.
        drive(1'b1, 1'b0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive(1'b0, 1'b0, 4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            for (int i = 0; i < 4; i++) if (out_grant[i]) cnt[i]++;
            if (out_grant !== 4'(1 << (k % 4)) || out_CDB_broadcast !== 1'b1 || out_CDB_src !== 2'(k % 4)) begin
                n_bad++;
                $display("FAIL rr%0d: got grant=%b bc=%b src=%0d, want grant=%b bc=1 src=%0d",
                         k, out_grant, out_CDB_broadcast, out_CDB_src, 4'(1 << (k % 4)), k % 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cnt[i] != 2) begin
                n_bad++;
                $display("FAIL share%0d: got %0d grants, want 2", i, cnt[i]);
            end
        end

        // Bounded wait: a lone requester after a hold must win within 4 edges.
        drive(1'b0, 1'b1, 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'b1000, 1'b0);
        begin
            int waited;
            waited = 0;
            while (out_grant !== 4'b1000 && waited < 4) begin
                @(posedge clk);
                #1;
                waited++;
            end
            n_vec++;
            if (out_grant !== 4'b1000 || out_CDB_tag !== 5'd9) begin
                n_bad++;
                $display("FAIL lone3: got grant=%b tag=%0d after %0d edges, want grant=1000 tag=9", out_grant, out_CDB_tag, waited);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
